regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, the successor to the single-write bank. It provides two combinational read ports, a general write port and a dedicated link write port for `jal`, with an optional hardwired zero register and optional write-to-read bypass. It also holds a per-register pending scoreboard for the hazard unit and a sequential clear engine that wipes the file without a global reset.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 65 ++++++
 rtl/regfile_mp.sv | 136 +++++++++++++
 tb/tb_regfile_mp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and clear-engine state encoding for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned LINK_REG_DEF = 31;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for the hazard unit: one set port, two write-clear ports,
// a sweep clear and two read taps that hide a bit being retired by a same-cycle write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_a_en_i,
  input  logic [ADDR_W-1:0] clr_a_addr_i,
  input  logic              clr_b_en_i,
  input  logic [ADDR_W-1:0] clr_b_addr_i,
  input  logic              sweep_en_i,
  input  logic [ADDR_W-1:0] sweep_addr_i,
  input  logic [ADDR_W-1:0] rd_a_addr_i,
  input  logic [ADDR_W-1:0] rd_b_addr_i,
  output logic              pend_a_c_o,
  output logic              pend_b_c_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0] tap_addr_c [2];
  logic              tap_pend_c [2];

  // Set is applied last so it wins over any clear of the same address.
  always_comb begin
    pend_d = pend_q;
    if (sweep_en_i) pend_d[sweep_addr_i] = 1'b0;
    if (clr_a_en_i) pend_d[clr_a_addr_i] = 1'b0;
    if (clr_b_en_i) pend_d[clr_b_addr_i] = 1'b0;
    if (set_en_i)   pend_d[set_addr_i]   = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign tap_addr_c[0] = rd_a_addr_i;
  assign tap_addr_c[1] = rd_b_addr_i;

  // A register written this cycle is already forwarded, so it is not pending unless re-marked.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      tap_pend_c[p] = pend_q[tap_addr_c[p]];
      if (BYPASS != 0 &&
          ((clr_a_en_i && clr_a_addr_i == tap_addr_c[p]) ||
           (clr_b_en_i && clr_b_addr_i == tap_addr_c[p])) &&
          !(set_en_i && set_addr_i == tap_addr_c[p]))
        tap_pend_c[p] = 1'b0;
    end
  end

  assign pend_a_c_o = tap_pend_c[0];
  assign pend_b_c_o = tap_pend_c[1];

endmodule

// File: rtl/regfile_mp.sv
// MIPS register file: two combinational read ports, general and link write ports,
// pending scoreboard and a one-register-per-cycle sweep clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LINK_REG = LINK_REG_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_pending,
  output logic              rt_pending,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int unsigned       DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              sweep_c;
  logic              wr_acc_c, link_acc_c, set_acc_c;
  logic [ADDR_W-1:0] rd_addr_c [2];
  logic [DATA_W-1:0] rd_data_c [2];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Clear engine: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear engine: next state; the index wraps to 0 as the sweep finishes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_SWEEP;
          idx_d   = '0;
        end
      end
      CLR_SWEEP: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_A) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Clear engine: outputs
  always_comb begin
    sweep_c = (state_q == CLR_SWEEP);
  end

  assign clr_busy   = sweep_c;
  assign wr_acc_c   = wr_en     && !sweep_c && !is_zero(wr_addr);
  assign link_acc_c = link_en   && !sweep_c && !is_zero(LINK_A);
  assign set_acc_c  = sb_set_en && !sweep_c && !is_zero(sb_set_addr);

  // Array update; the link write comes last so it wins on LINK_REG
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (sweep_c) begin
      regs_q[idx_q] <= '0;
    end else begin
      if (wr_acc_c)   regs_q[wr_addr] <= wr_data;
      if (link_acc_c) regs_q[LINK_A]  <= link_data;
    end
  end

  assign rd_addr_c[0] = rs_addr;
  assign rd_addr_c[1] = rt_addr;

  // Read mux, lowest priority first: array, general write, link write, zero register
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_c[p] = regs_q[rd_addr_c[p]];
      if (BYPASS != 0 && wr_acc_c && rd_addr_c[p] == wr_addr)  rd_data_c[p] = wr_data;
      if (BYPASS != 0 && link_acc_c && rd_addr_c[p] == LINK_A) rd_data_c[p] = link_data;
      if (is_zero(rd_addr_c[p])) rd_data_c[p] = '0;
    end
  end

  assign rs_data = rd_data_c[0];
  assign rt_data = rd_data_c[1];

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .set_en_i     (set_acc_c),
    .set_addr_i   (sb_set_addr),
    .clr_a_en_i   (wr_acc_c),
    .clr_a_addr_i (wr_addr),
    .clr_b_en_i   (link_acc_c),
    .clr_b_addr_i (LINK_A),
    .sweep_en_i   (sweep_c),
    .sweep_addr_i (idx_q),
    .rd_a_addr_i  (rs_addr),
    .rd_b_addr_i  (rt_addr),
    .pend_a_c_o   (rs_pending),
    .pend_b_c_o   (rt_pending)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: vector table through an expectation queue, then sweep and reset sequences.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, wr_addr, sb_set_addr;
  logic [31:0] rs_data, rt_data, wr_data, link_data;
  logic        rs_pending, rt_pending, wr_en, link_en, sb_set_en, clr_req, clr_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rs, rt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        le;
    logic [31:0] ld;
    logic        se;
    logic [4:0]  sa;
    logic [31:0] ers, ert;
    logic        ersp, ertp;
  } vec_t;

  typedef struct {
    logic [31:0] rs_d, rt_d;
    logic        rsp, rtp, busy;
  } exp_t;

  localparam int NV = 19;
  vec_t        vec [NV];
  exp_t        exp_q [$];
  exp_t        e;
  logic [31:0] m [32];
  int          cnt;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk         (clk),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .rs_pending  (rs_pending),
    .rt_pending  (rt_pending),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .link_en     (link_en),
    .link_data   (link_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_addr = '0; rt_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    link_en = 1'b0; link_data = '0; sb_set_en = 1'b0; sb_set_addr = '0; clr_req = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic le,
                               input logic [31:0] ld, input logic se, input logic [4:0] sa,
                               input logic [31:0] ers, input logic [31:0] ert,
                               input logic ersp, input logic ertp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.we = we; v.wa = wa; v.wd = wd; v.le = le; v.ld = ld;
    v.se = se; v.sa = sa; v.ers = ers; v.ert = ert; v.ersp = ersp; v.ertp = ertp;
    return v;
  endfunction

  // One address per cycle on rs and the mirrored address on rt; all must be zero and idle.
  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      idle();
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #4;
      chk($sformatf("%s_rs%0d", tag, a), rs_data, m[a]);
      chk($sformatf("%s_rt%0d", tag, 31 - a), rt_data, m[31 - a]);
      chk($sformatf("%s_pend%0d", tag, a), 32'(rs_pending), 32'(0));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = mkv(0,  1,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0);
    vec[1]  = mkv(5,  5,  1, 5,  32'hDEADBEEF, 0, 32'h0,        0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vec[2]  = mkv(0,  0,  1, 0,  32'h12345678, 0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 0);
    vec[3]  = mkv(0,  5,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'hDEADBEEF, 0, 0);
    vec[4]  = mkv(31, 31, 1, 31, 32'h11111111, 1, 32'h00400008, 0, 0,  32'h00400008, 32'h00400008, 0, 0);
    vec[5]  = mkv(31, 5,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h00400008, 32'hDEADBEEF, 0, 0);
    vec[6]  = mkv(7,  7,  0, 0,  32'h0,        0, 32'h0,        1, 7,  32'h0,        32'h0,        0, 0);
    vec[7]  = mkv(7,  7,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'h0,        1, 1);
    vec[8]  = mkv(6,  7,  1, 7,  32'h0000A5A5, 0, 32'h0,        0, 0,  32'h0,        32'h0000A5A5, 0, 0);
    vec[9]  = mkv(6,  7,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'h0000A5A5, 0, 0);
    vec[10] = mkv(6,  7,  0, 0,  32'h0,        0, 32'h0,        1, 7,  32'h0,        32'h0000A5A5, 0, 0);
    vec[11] = mkv(6,  7,  1, 7,  32'h00000077, 0, 32'h0,        1, 7,  32'h0,        32'h00000077, 0, 1);
    vec[12] = mkv(6,  7,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'h00000077, 0, 1);
    vec[13] = mkv(31, 7,  0, 0,  32'h0,        0, 32'h0,        1, 31, 32'h00400008, 32'h00000077, 0, 1);
    vec[14] = mkv(31, 7,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h00400008, 32'h00000077, 1, 1);
    vec[15] = mkv(31, 7,  0, 0,  32'h0,        1, 32'h00400010, 0, 0,  32'h00400010, 32'h00000077, 0, 1);
    vec[16] = mkv(31, 7,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h00400010, 32'h00000077, 0, 1);
    vec[17] = mkv(0,  7,  0, 0,  32'h0,        0, 32'h0,        1, 0,  32'h0,        32'h00000077, 0, 1);
    vec[18] = mkv(0,  7,  0, 0,  32'h0,        0, 32'h0,        0, 0,  32'h0,        32'h00000077, 0, 1);

    for (int i = 0; i < 32; i++) m[i] = '0;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    read_all("post_reset");
    chk("post_reset_busy", 32'(clr_busy), 32'(0));

    // Vector table: expectations queued as stimulus is driven, retired at the sample point
    for (int i = 0; i < NV; i++) begin
      idle();
      rs_addr = vec[i].rs; rt_addr = vec[i].rt;
      wr_en = vec[i].we; wr_addr = vec[i].wa; wr_data = vec[i].wd;
      link_en = vec[i].le; link_data = vec[i].ld;
      sb_set_en = vec[i].se; sb_set_addr = vec[i].sa;
      exp_q.push_back('{vec[i].ers, vec[i].ert, vec[i].ersp, vec[i].ertp, 1'b0});
      #4;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_rs_data", i), rs_data, e.rs_d);
      chk($sformatf("v%0d_rt_data", i), rt_data, e.rt_d);
      chk($sformatf("v%0d_rs_pend", i), 32'(rs_pending), 32'(e.rsp));
      chk($sformatf("v%0d_rt_pend", i), 32'(rt_pending), 32'(e.rtp));
      chk($sformatf("v%0d_busy", i), 32'(clr_busy), 32'(e.busy));
      step();
    end

    // Fill 1..31 with nonzero data, then mark two registers pending
    idle();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
      m[i] = wr_data;
      step();
    end
    idle();
    sb_set_en = 1'b1; sb_set_addr = 5'd7;  step();
    sb_set_addr = 5'd12; step();
    idle();
    rs_addr = 5'd17; rt_addr = 5'd12;
    #4;
    chk("fill_r17", rs_data, 32'h11111111);
    chk("fill_r12", rt_data, 32'h0C0C0C0C);
    chk("fill_pend12", 32'(rt_pending), 32'(1));
    step();

    // Sweep: count busy cycles, poke ignored writes/sets/requests mid-sweep
    idle();
    clr_req = 1'b1;
    step();
    idle();
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 5)  begin wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hBAD0BAD0; rs_addr = 5'd3; end
      if (j == 6)  clr_req = 1'b1;
      if (j == 10) begin rs_addr = 5'd9; rt_addr = 5'd10; end
      if (j == 12) begin sb_set_en = 1'b1; sb_set_addr = 5'd9; end
      #4;
      if (j == 5)  chk("sweep_wr_bypass", rs_data, 32'h0);
      if (j == 10) begin
        chk("sweep_partial_lo", rs_data, 32'h0);
        chk("sweep_partial_hi", rt_data, 32'h0A0A0A0A);
      end
      if (!clr_busy) break;
      cnt++;
      step();
      idle();
    end
    chk("sweep_len", 32'(cnt), 32'(32));
    step();
    for (int i = 0; i < 32; i++) m[i] = '0;
    read_all("post_sweep");

    // Reset in the middle of a sweep, at index 10
    idle();
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h20202020; step();
    wr_addr = 5'd2; wr_data = 32'h00000022; step();
    idle();
    clr_req = 1'b1; step();
    idle();
    repeat (10) step();
    chk("mid_sweep_busy", 32'(clr_busy), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    rs_addr = 5'd20;
    #3;
    chk("reset_busy", 32'(clr_busy), 32'(0));
    chk("reset_r20", rs_data, 32'h0);
    step();
    read_all("post_reset2");

    // Restarted sweep must begin again at index 0
    idle();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h00000022; step();
    idle();
    clr_req = 1'b1; step();
    idle();
    repeat (3) step();
    rs_addr = 5'd2;
    #3;
    chk("restart_r2_cleared", rs_data, 32'h0);
    step();
    idle();
    cnt = 4;
    for (int k = 0; k < 40; k++) begin
      #3;
      if (!clr_busy) break;
      cnt++;
      step();
    end
    chk("restart_len", 32'(cnt), 32'(32));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
